// File: rtl/dram_cmd_issue.sv
// Sequences one controller request into DRAM PRE/ACT/RD/WR/REF commands and
// enforces tRCD/tRP/tRAS/tCCD/tRFC with saturating per-constraint down-counters.
module dram_cmd_issue #(
    parameter int NUMBER_OF_BANKS = 8,
    parameter int T_RCD           = 3,
    parameter int T_RP            = 3,
    parameter int T_RAS           = 6,
    parameter int T_CCD           = 2,
    parameter int T_RFC           = 10
) (
    input  logic                               clk,
    input  logic                               rst_b,
    input  logic                               cmd_req,
    input  logic [1:0]                         cmd,
    input  logic [$clog2(NUMBER_OF_BANKS)-1:0] bank_rw,
    output logic                               cmd_ack,
    output logic [2:0]                         dram_cmd,
    output logic [$clog2(NUMBER_OF_BANKS)-1:0] dram_bank,
    output logic                               busy,
    output logic                               proto_err
);
    localparam int BW = $clog2(NUMBER_OF_BANKS);

    typedef enum logic [2:0] {
        IDLE, DECODE, WAIT_PRE, ISSUE_PRE, WAIT_MAIN, ISSUE_MAIN, WAIT_RFC, ACK
    } state_t;

    localparam logic [1:0] REQ_ACT = 2'd0;
    localparam logic [1:0] REQ_RD  = 2'd1;
    localparam logic [1:0] REQ_WR  = 2'd2;
    localparam logic [1:0] REQ_REF = 2'd3;

    localparam logic [2:0] DC_NOP = 3'd0;
    localparam logic [2:0] DC_ACT = 3'd1;
    localparam logic [2:0] DC_RD  = 3'd2;
    localparam logic [2:0] DC_WR  = 3'd3;
    localparam logic [2:0] DC_PRE = 3'd4;
    localparam logic [2:0] DC_REF = 3'd5;

    localparam int N_CNT = 5;
    localparam int C_RCD = 0;
    localparam int C_RP  = 1;
    localparam int C_RAS = 2;
    localparam int C_CCD = 3;
    localparam int C_RFC = 4;

    state_t          state_q, state_d;
    logic [1:0]      cmd_lat_q, cmd_lat_d;
    logic [BW-1:0]   bank_lat_q, bank_lat_d;
    logic [BW-1:0]   open_bank_q, open_bank_d;
    logic            row_open_q, row_open_d;
    logic            proto_err_q, proto_err_d;
    logic [2:0]      dram_cmd_q, dram_cmd_d;
    logic [BW-1:0]   dram_bank_q, dram_bank_d;
    logic [N_CNT-1:0] cnt_load;
    logic [N_CNT-1:0] cnt_zero;

    logic is_rw, need_pre, rw_no_row, main_ready;

    // Loaded with T-1 on the edge that places the command on dram_cmd, so the
    // dependent command can be driven exactly T cycles later.
    for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
        localparam int T_VAL = (gi == C_RCD) ? T_RCD :
                               (gi == C_RP)  ? T_RP  :
                               (gi == C_RAS) ? T_RAS :
                               (gi == C_CCD) ? T_CCD : T_RFC;
        localparam logic [3:0] LOAD = 4'(T_VAL - 1);
        logic [3:0] cnt_q;

        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b)              cnt_q <= '0;
            else if (cnt_load[gi])   cnt_q <= LOAD;
            else if (cnt_q != 4'd0)  cnt_q <= cnt_q - 4'd1;
        end

        assign cnt_zero[gi] = (cnt_q == 4'd0);
    end

    assign is_rw      = (cmd_lat_q == REQ_RD) || (cmd_lat_q == REQ_WR);
    assign need_pre   = !is_rw && row_open_q;
    assign rw_no_row  = is_rw && !row_open_q;
    assign main_ready = is_rw ? (cnt_zero[C_RCD] & cnt_zero[C_CCD])
                              : (cnt_zero[C_RP]  & cnt_zero[C_RFC]);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (cmd_req && !cmd_ack) state_d = DECODE;
            DECODE:     if (rw_no_row)           state_d = ACK;
                        else if (need_pre)       state_d = WAIT_PRE;
                        else                     state_d = WAIT_MAIN;
            WAIT_PRE:   if (cnt_zero[C_RAS])     state_d = ISSUE_PRE;
            ISSUE_PRE:                           state_d = WAIT_MAIN;
            WAIT_MAIN:  if (main_ready)          state_d = ISSUE_MAIN;
            ISSUE_MAIN: state_d = (cmd_lat_q == REQ_REF) ? WAIT_RFC : ACK;
            WAIT_RFC:   if (cnt_zero[C_RFC])     state_d = ACK;
            ACK:        if (!cmd_req)            state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_lat_d   = cmd_lat_q;
        bank_lat_d  = bank_lat_q;
        open_bank_d = open_bank_q;
        row_open_d  = row_open_q;
        proto_err_d = proto_err_q;
        dram_cmd_d  = DC_NOP;
        dram_bank_d = '0;
        cnt_load    = '0;

        if (state_q == IDLE && state_d == DECODE) begin
            cmd_lat_d  = cmd;
            bank_lat_d = bank_rw;
        end
        if (state_q == DECODE && rw_no_row) proto_err_d = 1'b1;

        if (state_d == ISSUE_PRE) begin
            dram_cmd_d     = DC_PRE;
            dram_bank_d    = open_bank_q;
            row_open_d     = 1'b0;
            cnt_load[C_RP] = 1'b1;
        end

        if (state_d == ISSUE_MAIN) begin
            dram_bank_d = bank_lat_q;
            unique case (cmd_lat_q)
                REQ_ACT: begin
                    dram_cmd_d      = DC_ACT;
                    row_open_d      = 1'b1;
                    open_bank_d     = bank_lat_q;
                    cnt_load[C_RCD] = 1'b1;
                    cnt_load[C_RAS] = 1'b1;
                end
                REQ_RD: begin
                    dram_cmd_d      = DC_RD;
                    cnt_load[C_CCD] = 1'b1;
                end
                REQ_WR: begin
                    dram_cmd_d      = DC_WR;
                    cnt_load[C_CCD] = 1'b1;
                end
                default: begin
                    dram_cmd_d      = DC_REF;
                    dram_bank_d     = '0;
                    cnt_load[C_RFC] = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cmd_lat_q   <= REQ_ACT;
            bank_lat_q  <= '0;
            open_bank_q <= '0;
            row_open_q  <= 1'b0;
            proto_err_q <= 1'b0;
            dram_cmd_q  <= DC_NOP;
            dram_bank_q <= '0;
        end else begin
            cmd_lat_q   <= cmd_lat_d;
            bank_lat_q  <= bank_lat_d;
            open_bank_q <= open_bank_d;
            row_open_q  <= row_open_d;
            proto_err_q <= proto_err_d;
            dram_cmd_q  <= dram_cmd_d;
            dram_bank_q <= dram_bank_d;
        end
    end

    assign cmd_ack   = (state_q == ACK);
    assign busy      = (state_q != IDLE);
    assign dram_cmd  = dram_cmd_q;
    assign dram_bank = dram_bank_q;
    assign proto_err = proto_err_q;

endmodule
